toggle_cover_collector: RTL and testbench
=========================================

Name: toggle_cover_collector

Overview:
- Upstream stage of the per-module toggle coverage reporter.
- Samples a monitored WIDTH-bit signal bus and tracks, per bit, whether a rising and a falling transition have been seen.
- When a bit becomes fully toggled for the first time, it emits a one-cycle pulse on the matching valid bit. This vector feeds the reporter's valid input directly.
- Also keeps a sticky coverage map, a covered-bit counter and an all-covered flag.

Parameters:
- WIDTH, 28, number of monitored bits; equals the valid width of the downstream reporter.
- CNT_W, $clog2(WIDTH+1), width of covered_cnt (derived; not to be overridden).

Ports:
- clock  input  1  clock, rising-edge.
- reset  input  1  reset, synchronous, active-low.
- en  input  1  sampling enable; when 0, sig is ignored and no edges are recorded.
- clear  input  1  synchronous coverage clear (active-high).
- sig  input  WIDTH  monitored signal bus.
- valid  output  WIDTH  one-cycle pulse per bit on first full toggle.
- covered  output  WIDTH  sticky per-bit coverage map.
- covered_cnt  output  CNT_W  population count of covered.
- all_covered  output  1  high when covered is all ones.

Behaviour:
- Reset is applied when reset==0 at a rising clock edge. It has priority over clear and en.
- Reset values:
  - valid=0, covered=0, covered_cnt=0, all_covered=0.
  - Internal prev=0, rise_seen=0, fall_seen=0, state=PRIME.
- States:
  - PRIME: waits for the first enabled cycle, captures prev<=sig, records no edges, then goes to ARMED. The value present at reset release never counts as a transition.
  - ARMED: each enabled cycle:
    - rise = ~prev & sig; fall = prev & ~sig.
    - rise_seen |= rise; fall_seen |= fall; prev <= sig.
    - When covered == all ones after the update, go to DONE.
  - DONE: edge tracking stops and valid stays 0. Outputs hold.
- Coverage rule:
  - covered_next = rise_seen_next & fall_seen_next.
  - valid (registered) = covered_next & ~covered.
  - valid is asserted the cycle after the completing edge is sampled, for exactly one cycle, at most once per bit between clears.
- Several bits may complete in the same cycle. All of them pulse together.
- en=0 in ARMED:
  - prev is not updated and no edges are recorded.
  - A transition that spans a disabled window counts when en returns, since sig is compared against the last enabled sample.
- clear=1 (reset deasserted):
  - rise_seen, fall_seen, covered, covered_cnt, all_covered and valid go to 0 next cycle.
  - state=PRIME.
  - clear overrides edge detection in the same cycle, so no valid is emitted for that cycle.
- covered_cnt is registered and updated in the same cycle as covered. It is the incremental count of newly covered bits, and saturates at WIDTH by construction.
- all_covered is registered, and equals (covered_cnt==WIDTH) in the same cycle.
- sig is not synchronised here; it must be synchronous to clock.

Optional Feature:
- Macro: TOGGLE_COVER_SINGLE_EDGE_EN.
- Defined: a bit is covered on its first transition in either direction (covered_next = rise_seen_next | fall_seen_next). valid pulses one cycle after that first edge.
- Undefined: a rise and a fall are both required (default rule above).

Test Plan:
- Reset hold (reset=0 for 3 cycles, sig toggling) -> valid, covered, covered_cnt all 0. After release with sig=28'h0000001, the first enabled cycle only primes and no valid follows.
- Bit 0 toggle 0->1->0 with en=1 -> valid=28'h1 for exactly one cycle, one cycle after the fall sample. covered[0]=1, covered_cnt=1. A second 0->1->0 produces no further valid.
- sig 28'h0 -> 28'hFFFFFFF -> 28'h0 -> valid=28'hFFFFFFF one cycle, covered_cnt=28, all_covered=1, state DONE. Further toggles give valid=0.
- en=0 while sig goes 0->1 and back to 0, then en=1 -> no edge recorded and no valid. Separately, rise during en=0 then en=1 -> rise is recorded on the first enabled sample.
- After full coverage, assert clear for 1 cycle coincident with a bit-3 fall -> covered=0, covered_cnt=0, all_covered=0, no valid. Next enabled cycle primes.
- With TOGGLE_COVER_SINGLE_EDGE_EN, a single bit-5 rise -> valid=28'h20 one cycle later, covered_cnt=1. Without the macro, the same stimulus gives valid=0.

Source files
------------

// File: rtl/toggle_cover_collector.sv
// ---------------------------------------------------------------------------
// toggle_cover_collector
//
// Upstream stage of the per-module toggle coverage reporter. Samples a
// WIDTH-bit bus and tracks, per bit, whether a rising and a falling
// transition have been seen. When a bit becomes covered for the first time
// a one-cycle pulse is emitted on the matching bit of valid; that vector
// feeds the reporter's valid input directly. A sticky coverage map, a
// covered-bit counter and an all-covered flag are also kept.
//
// Optional feature (compile-time macro TOGGLE_COVER_SINGLE_EDGE_EN):
//   defined   -> a bit is covered on its first edge in either direction
//   undefined -> a bit needs both a rise and a fall (default)
//
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous, active-low reset (beats clear/en)
//   en           in   1      sampling enable; sig ignored while low
//   clear        in   1      synchronous coverage clear, active-high
//   sig          in   WIDTH  monitored bus, already synchronous to clock
//   valid        out  WIDTH  one-cycle pulse per bit on first coverage
//   covered      out  WIDTH  sticky per-bit coverage map
//   covered_cnt  out  CNT_W  population count of covered
//   all_covered  out  1      high when every bit is covered
// ---------------------------------------------------------------------------
module toggle_cover_collector #(
  parameter  int WIDTH = 28,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    PRIME = 2'd0,  // capture a reference sample, record nothing
    ARMED = 2'd1,  // record edges against the last enabled sample
    DONE  = 2'd2   // everything covered, outputs frozen
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   rise_seen_q;
  logic [WIDTH-1:0]   fall_seen_q;
  logic [WIDTH-1:0]   covered_q;
  logic [WIDTH-1:0]   valid_q;
  logic [CNT_W-1:0]   covered_cnt_q;
  logic               all_covered_q;

  logic [WIDTH-1:0]   rise_seen_d;
  logic [WIDTH-1:0]   fall_seen_d;
  logic [WIDTH-1:0]   covered_d;
  logic [WIDTH-1:0]   newly_d;
  logic [CNT_W-1:0]   covered_cnt_d;

  // Candidate next coverage, used only when an ARMED cycle is enabled.
  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no latch can be inferred; the clocked block uses '<='.
  always_comb begin
    rise_seen_d = rise_seen_q | (~prev_q & sig);
    fall_seen_d = fall_seen_q | (prev_q & ~sig);
`ifdef TOGGLE_COVER_SINGLE_EDGE_EN
    covered_d   = rise_seen_d | fall_seen_d;
`else
    covered_d   = rise_seen_d & fall_seen_d;
`endif
    // Coverage is monotonic between clears, so the count grows by the
    // number of bits completing this cycle and cannot pass WIDTH.
    newly_d       = covered_d & ~covered_q;
    covered_cnt_d = covered_cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      covered_cnt_d = covered_cnt_d + CNT_W'(newly_d[i]);
    end
  end

  // NOTE: every register, including the per-bit history, is cleared by the
  // synchronous reset; nothing here is a RAM, so there is no cost to it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= PRIME;
      prev_q        <= '0;
      rise_seen_q   <= '0;
      fall_seen_q   <= '0;
      covered_q     <= '0;
      valid_q       <= '0;
      covered_cnt_q <= '0;
      all_covered_q <= 1'b0;
    end else if (clear) begin
      // prev is left alone: PRIME recaptures it before any edge is counted.
      state_q       <= PRIME;
      rise_seen_q   <= '0;
      fall_seen_q   <= '0;
      covered_q     <= '0;
      valid_q       <= '0;
      covered_cnt_q <= '0;
      all_covered_q <= 1'b0;
    end else begin
      valid_q <= '0;  // pulse lasts one cycle unless re-asserted below
      unique case (state_q)
        PRIME: begin
          if (en) begin
            prev_q  <= sig;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (en) begin
            prev_q        <= sig;
            rise_seen_q   <= rise_seen_d;
            fall_seen_q   <= fall_seen_d;
            covered_q     <= covered_d;
            valid_q       <= newly_d;
            covered_cnt_q <= covered_cnt_d;
            all_covered_q <= (covered_cnt_d == FULL_CNT);
            if (&covered_d) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // Hold until clear or reset.
        end
        default: begin
          state_q <= PRIME;
        end
      endcase
    end
  end

  assign valid       = valid_q;
  assign covered     = covered_q;
  assign covered_cnt = covered_cnt_q;
  assign all_covered = all_covered_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// ---------------------------------------------------------------------------
// tb_toggle_cover_collector
//
// Self-checking bench for toggle_cover_collector in its default build (both
// a rise and a fall needed per bit). A table of directed vectors, each with
// hand-computed expected outputs after the clock edge, is applied in order;
// a short hand-written sequence then covers clear colliding with a
// completing edge and the valid latency/width.
// ---------------------------------------------------------------------------
module tb_toggle_cover_collector;

  localparam int WIDTH = 28;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  logic             clock;
  logic             reset;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] covered;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  toggle_cover_collector #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .covered     (covered),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             rst_n;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] exp_valid;
    logic [WIDTH-1:0] exp_cov;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_all;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic e, input logic c,
                     input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] v,
                     input logic [WIDTH-1:0] cv, input int n, input logic a);
    vec_t t;
    t.rst_n = r; t.en = e; t.clr = c; t.sig = s;
    t.exp_valid = v; t.exp_cov = cv; t.exp_cnt = CNT_W'(n); t.exp_all = a;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic c,
                      input logic [WIDTH-1:0] s);
    reset = r; en = e; clear = c; sig = s;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] v,
                               input logic [WIDTH-1:0] cv, input int n,
                               input logic a);
    check({tag, ".valid"},       32'(valid),       32'(v));
    check({tag, ".covered"},     32'(covered),     32'(cv));
    check({tag, ".covered_cnt"}, 32'(covered_cnt), 32'(n));
    check({tag, ".all_covered"}, 32'(all_covered), 32'(a));
  endtask

  initial begin
    int cycles;
    reset = 1'b0; en = 1'b0; clear = 1'b0; sig = '0;

    //   rst en clr sig            valid         covered       cnt all
    // Reset held three cycles with sig toggling.
    add(0, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(0, 1, 0, ALL1,           28'h0,        28'h0,        0,  0);
    add(0, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    // Release with sig=1: prime, then no edge and no valid.
    add(1, 1, 0, 28'h1,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h1,          28'h0,        28'h0,        0,  0);
    // Re-reset and prime at 0 for the bit-0 toggle.
    add(0, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h1,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h0,          28'h1,        28'h1,        1,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h1,        1,  0);
    // Second bit-0 toggle: no further valid.
    add(1, 1, 0, 28'h1,          28'h0,        28'h1,        1,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h1,        1,  0);
    // Bit-1 pulse entirely inside en=0: nothing recorded.
    add(1, 0, 0, 28'h2,          28'h0,        28'h1,        1,  0);
    add(1, 0, 0, 28'h0,          28'h0,        28'h1,        1,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h1,        1,  0);
    // Rise during en=0 counts on the first enabled sample.
    add(1, 0, 0, 28'h2,          28'h0,        28'h1,        1,  0);
    add(1, 1, 0, 28'h2,          28'h0,        28'h1,        1,  0);
    add(1, 1, 0, 28'h0,          28'h2,        28'h3,        2,  0);
    // Clear, prime, then full-width toggle: all bits pulse together.
    add(1, 1, 1, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, ALL1,           28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h0,          ALL1,         ALL1,         28, 1);
    // DONE: further toggles do nothing.
    add(1, 1, 0, ALL1,           28'h0,        ALL1,         28, 1);
    add(1, 1, 0, 28'h0,          28'h0,        ALL1,         28, 1);
    add(1, 1, 0, 28'h8,          28'h0,        ALL1,         28, 1);
    // Clear coincident with a bit-3 fall.
    add(1, 1, 1, 28'h0,          28'h0,        28'h0,        0,  0);
    // Next enabled cycle primes at 8; a fall then a rise completes bit 3.
    add(1, 1, 0, 28'h8,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h8,          28'h8,        28'h8,        1,  0);
    // Single bit-5 rise: not enough for coverage in the default build.
    add(0, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h0,          28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h20,         28'h0,        28'h0,        0,  0);
    add(1, 1, 0, 28'h20,         28'h0,        28'h0,        0,  0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].clr, vecs[i].sig);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid,
                    vecs[i].exp_cov, int'(vecs[i].exp_cnt), vecs[i].exp_all);
    end

    // Bit 5 has its rise recorded; clear in the same cycle as the completing
    // fall must win, so no pulse appears.
    step(1, 1, 1, 28'h0);
    check_outputs("clr_vs_edge", 28'h0, 28'h0, 0, 0);
    check("clr_vs_edge.no_late_valid", 32'(valid), 32'h0);

    // Prime, rise, fall on bit 5; wait (bounded) for the pulse.
    step(1, 1, 0, 28'h0);
    step(1, 1, 0, 28'h20);
    check("b5_rise.valid", 32'(valid), 32'h0);
    step(1, 1, 0, 28'h0);
    cycles = 0;
    while (valid == '0 && cycles < 4) begin
      step(1, 1, 0, 28'h0);
      cycles++;
    end
    check("b5_valid_latency", 32'(cycles), 32'd0);
    check("b5_valid_value",   32'(valid),  32'h20);
    step(1, 1, 0, 28'h0);
    check_outputs("b5_after", 28'h0, 28'h20, 1, 0);

    // Reset beats clear and en.
    step(0, 1, 1, ALL1);
    check_outputs("rst_over_clr", 28'h0, 28'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
